// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the combinational ROM read port between fetch (IF) and load (LD) with round-robin and 1-cycle registered responses.
// Optional ROM_ARB_ALIGN_CHECK_EN: misaligned granted requests return rdata=0 with err=1.
module rom_port_arbiter #(
  parameter int COUNTER_WIDTH    = 12,
  parameter int INSTRUCTON_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        if_req,
  input  logic [COUNTER_WIDTH-1:0]    if_addr,
  output logic                        if_gnt,
  output logic                        if_rvalid,
  output logic [INSTRUCTON_WIDTH-1:0] if_rdata,
  input  logic                        if_rready,
  output logic                        if_err,
  input  logic                        ld_req,
  input  logic [COUNTER_WIDTH-1:0]    ld_addr,
  output logic                        ld_gnt,
  output logic                        ld_rvalid,
  output logic [INSTRUCTON_WIDTH-1:0] ld_rdata,
  input  logic                        ld_rready,
  output logic                        ld_err,
  output logic [COUNTER_WIDTH-1:0]    rom_addr,
  input  logic [INSTRUCTON_WIDTH-1:0] rom_data,
  output logic                        busy
);
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_LD} state_t;
  state_t                      state_q, state_d;
  logic                        last_ld_q, last_ld_d;
  logic [INSTRUCTON_WIDTH-1:0] rdata_q, rdata_d;
  logic                        consume, can_grant, grant, misalign;
  assign if_rvalid = state_q == RESP_IF;
  assign ld_rvalid = state_q == RESP_LD;
  assign if_rdata  = rdata_q;
  assign ld_rdata  = rdata_q;
  assign busy      = state_q != IDLE;
  // A consumed response frees the register in the same cycle, allowing 1 word/cycle.
  assign consume   = (if_rvalid & if_rready) | (ld_rvalid & ld_rready);
  assign can_grant = (state_q == IDLE) | consume;
  assign if_gnt    = can_grant & if_req & (~ld_req | last_ld_q);
  assign ld_gnt    = can_grant & ld_req & (~if_req | ~last_ld_q);
  assign grant     = if_gnt | ld_gnt;
  assign rom_addr  = if_gnt ? if_addr : ld_gnt ? ld_addr : '0;
`ifdef ROM_ARB_ALIGN_CHECK_EN
  logic err_q;
  assign misalign = |rom_addr[1:0];
  assign if_err   = if_rvalid & err_q;
  assign ld_err   = ld_rvalid & err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else if (grant) err_q <= misalign;
`else
  assign misalign = 1'b0;
  assign if_err   = 1'b0;
  assign ld_err   = 1'b0;
`endif
  always_comb begin
    state_d   = if_gnt ? RESP_IF : ld_gnt ? RESP_LD : consume ? IDLE : state_q;
    last_ld_d = ld_gnt ? 1'b1 : if_gnt ? 1'b0 : last_ld_q;
    rdata_d   = grant ? (misalign ? '0 : rom_data) : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      last_ld_q <= 1'b1;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_ld_q <= last_ld_d;
      rdata_q   <= rdata_d;
    end
endmodule
